ls194_feeder: RTL and testbench



---
 rtl/ls194_pkg.sv | 20 ++
 rtl/ls194_bit_timer.sv | 47 ++++
 rtl/ls194_feeder.sv | 129 ++++++++++++
 tb/tb_ls194_feeder.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ls194_pkg.sv
// Shared mode codes and sequencer states for the LS194 feeder.
package ls194_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SR   = 2'b01;
  localparam logic [1:0] MODE_SL   = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Shift code for a transfer direction (0 = right via SR, 1 = left via SL).
  function automatic logic [1:0] shift_mode(input logic left);
    return left ? MODE_SL : MODE_SR;
  endfunction

endpackage

// File: rtl/ls194_bit_timer.sv
// Bit-period down-counter: flags the last cycle of each bit period, both for the
// current cycle and for the cycle after the coming edge.
module ls194_bit_timer #(
  parameter int unsigned BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic step,
  output logic last_c,
  output logic last_nxt_c
);

  if (BIT_CYCLES == 1) begin : g_tie
    logic unused_tie;
    assign unused_tie = &{1'b0, clk, rst_n, load, step};
    assign last_c     = 1'b1;
    assign last_nxt_c = 1'b1;
  end else begin : g_cnt
    localparam int unsigned CW  = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] TOP = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Reload on accept and at each period end; otherwise count down while stepping.
    always_comb begin
      cnt_d = cnt_q;
      if (load) begin
        cnt_d = TOP;
      end else if (step) begin
        cnt_d = (cnt_q == '0) ? TOP : cnt_q - CW'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign last_c     = (cnt_q == '0);
    assign last_nxt_c = (cnt_d == '0);
  end

endmodule

// File: rtl/ls194_feeder.sv
// Serialises a parallel word into an SN74LS194 chain by driving S1/S0 and SR/SL,
// one bit per BIT_CYCLES clocks, with a start/ready handshake and a done pulse.
module ls194_feeder
  import ls194_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned BIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             CR,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic             dir,
  output logic             ready,
  output logic             S1,
  output logic             S0,
  output logic             SR,
  output logic             SL,
  output logic             done
);

  localparam int unsigned BCW = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             dirq_q, dirq_d;
  logic [BCW-1:0]   bitcnt_q, bitcnt_d;
  logic [1:0]       mode_q, mode_d;
  logic             sr_q, sr_d, sl_q, sl_d;
  logic             ready_q, ready_d, done_q, done_d;
  logic             cur_bit;
  logic             t_load, t_step, last_c, last_nxt_c;

  assign t_load = (state_q == IDLE) && start;
  assign t_step = (state_q == SHIFT);

  ls194_bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
    .clk        (clk),
    .rst_n      (CR),
    .load       (t_load),
    .step       (t_step),
    .last_c     (last_c),
    .last_nxt_c (last_nxt_c)
  );

  // Next state plus next values of every registered output.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    dirq_d   = dirq_q;
    bitcnt_d = bitcnt_q;
    mode_d   = MODE_HOLD;
    sr_d     = 1'b0;
    sl_d     = 1'b0;
    ready_d  = 1'b0;
    done_d   = 1'b0;
    cur_bit  = 1'b0;

    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (start) begin
          shreg_d  = din;
          dirq_d   = dir;
          bitcnt_d = BCW'(WIDTH);
          ready_d  = 1'b0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (last_c) begin
          shreg_d  = dirq_q ? (shreg_q << 1) : (shreg_q >> 1);
          bitcnt_d = bitcnt_q - BCW'(1);
          if (bitcnt_q == BCW'(1)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // The bit on the serial pin is always the shreg end facing the chain.
    if (state_d == SHIFT) begin
      cur_bit = dirq_d ? shreg_d[WIDTH-1] : shreg_d[0];
      sr_d    = ~dirq_d & cur_bit;
      sl_d    = dirq_d & cur_bit;
      if (last_nxt_c) begin
        mode_d = shift_mode(dirq_d);
      end
    end
  end

  always_ff @(posedge clk or negedge CR) begin
    if (!CR) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      dirq_q   <= 1'b0;
      bitcnt_q <= '0;
      mode_q   <= MODE_HOLD;
      sr_q     <= 1'b0;
      sl_q     <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      dirq_q   <= dirq_d;
      bitcnt_q <= bitcnt_d;
      mode_q   <= mode_d;
      sr_q     <= sr_d;
      sl_q     <= sl_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

  assign ready = ready_q;
  assign S1    = mode_q[1];
  assign S0    = mode_q[0];
  assign SR    = sr_q;
  assign SL    = sl_q;
  assign done  = done_q;

endmodule

// File: tb/tb_ls194_feeder.sv
// Bench for ls194_feeder: two instances (BIT_CYCLES 1 and 3) feeding modelled LS194 chains.
module tb_ls194_feeder;
  import ls194_pkg::*;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         cr;
  logic         start [2];
  logic [W-1:0] din   [2];
  logic         dir   [2];
  logic         ready [2];
  logic         s1    [2];
  logic         s0    [2];
  logic         sr    [2];
  logic         sl    [2];
  logic         done  [2];

  int checks = 0;
  int errors = 0;
  bit run    = 1'b0;

  always #5 clk = ~clk;

  ls194_feeder #(.WIDTH(W), .BIT_CYCLES(1)) dut0 (
    .clk(clk), .CR(cr), .start(start[0]), .din(din[0]), .dir(dir[0]),
    .ready(ready[0]), .S1(s1[0]), .S0(s0[0]), .SR(sr[0]), .SL(sl[0]), .done(done[0])
  );

  ls194_feeder #(.WIDTH(W), .BIT_CYCLES(3)) dut1 (
    .clk(clk), .CR(cr), .start(start[1]), .din(din[1]), .dir(dir[1]),
    .ready(ready[1]), .S1(s1[1]), .S0(s0[1]), .SR(sr[1]), .SL(sl[1]), .done(done[1])
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Golden consumer: LS194 chain, q[W-1] = QA ... q[0] = far QD.
  logic [W-1:0] q [2];
  always @(posedge clk or negedge cr) begin
    if (!cr) begin
      q[0] <= '0;
      q[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        case ({s1[i], s0[i]})
          2'b01:   q[i] <= {sr[i], q[i][W-1:1]};
          2'b10:   q[i] <= {q[i][W-2:0], sl[i]};
          2'b11:   q[i] <= '0;
          default: q[i] <= q[i];
        endcase
      end
    end
  end

  // Transaction model: p = edges since the accepting edge of the current transfer.
  int           p    [2];
  bit           busy [2];
  logic [W-1:0] mw   [2];
  logic         md   [2];

  function automatic int bc_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  always @(posedge clk or negedge cr) begin
    if (!cr) begin
      for (int i = 0; i < 2; i++) begin
        busy[i] = 1'b0;
        p[i]    = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (busy[i]) begin
          p[i]++;
          if (p[i] > W * bc_of(i)) busy[i] = 1'b0;
        end else if (start[i]) begin
          busy[i] = 1'b1;
          p[i]    = 0;
          mw[i]   = din[i];
          md[i]   = dir[i];
        end
      end
    end
  end

  // Expected {ready, S1, S0, SR, SL, done} for instance i in the current cycle.
  function automatic logic [5:0] exp_out(input int i);
    int         bc;
    int         b;
    logic       bv;
    logic [1:0] m;
    bc = bc_of(i);
    if (!busy[i]) return 6'b100000;
    if (p[i] < W * bc) begin
      b  = p[i] / bc;
      bv = md[i] ? mw[i][W-1-b] : mw[i][b];
      m  = ((p[i] % bc) == bc - 1) ? (md[i] ? 2'b10 : 2'b01) : 2'b00;
      return {1'b0, m, md[i] ? 1'b0 : bv, md[i] ? bv : 1'b0, 1'b0};
    end
    return 6'b000001;
  endfunction

  always @(negedge clk) begin
    if (run) begin
      for (int i = 0; i < 2; i++) begin
        logic [5:0] e;
        logic [5:0] a;
        e = exp_out(i);
        a = {ready[i], s1[i], s0[i], sr[i], sl[i], done[i]};
        chk($sformatf("outputs dut%0d {rdy,S1,S0,SR,SL,done}=%b want %b", i, a, e), int'(a), int'(e));
        if (e[0]) chk($sformatf("chain dut%0d", i), int'(q[i]), int'(mw[i]));
      end
    end
  end

  // BIT_CYCLES=1 transfer on dut0; seq lists the expected serial bits first-to-last, MSB first.
  task automatic xfer_bc1(input logic [W-1:0] w, input logic d,
                          input logic [W-1:0] seq, input logic [W-1:0] chain_exp);
    @(negedge clk);
    #1;
    din[0]   = w;
    dir[0]   = d;
    start[0] = 1'b1;
    for (int k = 0; k < int'(W); k++) begin
      @(negedge clk);
      start[0] = 1'b0;
      chk("serial bit", d ? int'(sl[0]) : int'(sr[0]), int'(seq[W-1-k]));
      chk("idle serial pin", d ? int'(sr[0]) : int'(sl[0]), 0);
      chk("shift mode", int'({s1[0], s0[0]}), d ? 2 : 1);
      chk("ready busy", int'(ready[0]), 0);
    end
    @(negedge clk);
    chk("done pulse", int'(done[0]), 1);
    chk("done mode hold", int'({s1[0], s0[0]}), 0);
    chk("chain word", int'(q[0]), int'(chain_exp));
    @(negedge clk);
    chk("done cleared", int'(done[0]), 0);
    chk("ready back", int'(ready[0]), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    int nlow;
    int nshift;
    int t1;
    int t2;
    bit prev_ready;
    logic [W-1:0] c1;
    logic [W-1:0] c2;
    int bits3 [4] = '{0, 1, 1, 0};

    cr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0;
      din[i]   = '0;
      dir[i]   = 1'b0;
    end

    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset ready", int'(ready[i]), 1);
      chk("reset mode", int'({s1[i], s0[i]}), 0);
      chk("reset SR/SL", int'({sr[i], sl[i]}), 0);
      chk("reset done", int'(done[i]), 0);
    end
    #1;
    cr  = 1'b1;
    run = 1'b1;

    // Right and left shifts of 1011.
    xfer_bc1(4'b1011, 1'b0, 4'b1101, 4'b1011);
    xfer_bc1(4'b1011, 1'b1, 4'b1011, 4'b1011);

    // Stretched bits: 0110 shifted right, three cycles per bit.
    @(negedge clk);
    #1;
    din[1]   = 4'b0110;
    dir[1]   = 1'b0;
    start[1] = 1'b1;
    nshift   = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      start[1] = 1'b0;
      chk("bc3 SR bit", int'(sr[1]), bits3[k / 3]);
      chk("bc3 mode", int'({s1[1], s0[1]}), ((k % 3) == 2) ? 1 : 0);
      if ({s1[1], s0[1]} == 2'b01) nshift++;
    end
    @(negedge clk);
    chk("bc3 done", int'(done[1]), 1);
    chk("bc3 chain", int'(q[1]), 4'b0110);
    chk("bc3 shift count", nshift, 4);

    // start pulsed while busy is ignored.
    @(negedge clk);
    #1;
    din[0]   = 4'h9;
    dir[0]   = 1'b1;
    start[0] = 1'b1;
    ndone    = 0;
    nlow     = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      start[0] = (n == 2);
      if (done[0]) ndone++;
      if (!ready[0]) nlow++;
    end
    chk("busy start done count", ndone, 1);
    chk("busy start ready-low cycles", nlow, 5);

    // Clear mid-transfer aborts without a done pulse.
    @(negedge clk);
    #1;
    din[0]   = 4'h6;
    dir[0]   = 1'b0;
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    cr = 1'b0;
    #1;
    chk("abort ready", int'(ready[0]), 1);
    chk("abort mode", int'({s1[0], s0[0]}), 0);
    chk("abort SR/SL", int'({sr[0], sl[0]}), 0);
    chk("abort done", int'(done[0]), 0);
    @(negedge clk);
    #1;
    cr    = 1'b1;
    ndone = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (done[0]) ndone++;
    end
    chk("abort no done", ndone, 0);
    xfer_bc1(4'b1111, 1'b0, 4'b1111, 4'b1111);

    // start held high: back-to-back 5 then A.
    @(negedge clk);
    #1;
    din[0]     = 4'h5;
    dir[0]     = 1'b0;
    start[0]   = 1'b1;
    t1         = -1;
    t2         = -1;
    ndone      = 0;
    prev_ready = 1'b1;
    c1         = '0;
    c2         = '0;
    for (int n = 0; n < 30 && ndone < 2; n++) begin
      @(negedge clk);
      if (!ready[0] && prev_ready) begin
        if (t1 < 0) begin
          t1     = n;
          din[0] = 4'hA;
        end else if (t2 < 0) begin
          t2 = n;
        end
      end
      if (done[0]) begin
        if (ndone == 0) c1 = q[0];
        else c2 = q[0];
        ndone++;
      end
      prev_ready = ready[0];
    end
    start[0] = 1'b0;
    chk("b2b done count", ndone, 2);
    chk("b2b accept spacing", (t1 >= 0 && t2 >= 0) ? t2 - t1 : -1, 6);
    chk("b2b first chain", int'(c1), 4'b0101);
    chk("b2b second chain", int'(c2), 4'b1010);

    repeat (4) @(negedge clk);
    run = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
